// File: rtl/seq_mult4_if.sv
// Start/operand/result bundle for the sequential shift-and-add multiplier.
// The master drives operands and start; the slave returns product, busy and done.
interface seq_mult4_if #(
  parameter int unsigned N = 4
);
  logic             start;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic [2*N-1:0]   product;
  logic             busy;
  logic             done;

  modport master (
    output start,
    output a,
    output b,
    input  product,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output product,
    output busy,
    output done
  );
endinterface

// File: rtl/seq_mult4.sv
// Unsigned N x N sequential multiplier: one ripple-carry adder, N add/shift iterations,
// IDLE -> CALC (N cycles) -> DONE (1 cycle) control flow.
module seq_mult4 #(
  parameter int unsigned N = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_mult4_if.slave  bus
);

  localparam int unsigned CntW = $clog2(N + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     m_q, m_d;
  // Accumulator {HI, LO}; the C bit is always zero after each shift, so the
  // add carry only exists combinationally before it moves into HI[N-1].
  logic [2*N-1:0]   acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0]   product_q, product_d;

  logic [N-1:0]     hi;
  logic [N-1:0]     lo;
  logic [N-1:0]     addend;
  logic [N-1:0]     sum;
  logic [N:0]       carry;
  logic [2*N-1:0]   acc_shift;

  assign hi = acc_q[2*N-1:N];
  assign lo = acc_q[N-1:0];

  // Gating M by LO[0] makes the no-add case fall out of the same adder: HI + 0.
  assign addend = m_q & {N{lo[0]}};

  // Ripple chain of full-adder cells, carry-in of bit 0 tied low.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      sum[i]     = hi[i] ^ addend[i] ^ carry[i];
      carry[i+1] = (hi[i] & addend[i]) | (hi[i] & carry[i]) | (addend[i] & carry[i]);
    end
  end

  assign acc_shift = {carry[N], sum, lo[N-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          m_d     = bus.a;
          acc_d   = {{N{1'b0}}, bus.b};
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d = acc_shift;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          product_d = acc_shift;
          state_d   = StDone;
        end
      end
      StDone: begin
        // start is deliberately not looked at here; it is taken next cycle in IDLE.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      m_q       <= m_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = (state_q == StDone);

endmodule

// File: tb/tb_seq_mult4.sv
// Directed bench for seq_mult4 (N=4): corner products, held start, mid-op reset,
// and a back-to-back sweep of all operand pairs.
module tb_seq_mult4;

  localparam int unsigned N = 4;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  int   done_total;
  int   done_viol;
  logic done_prev;

  seq_mult4_if #(.N(N)) bus ();

  seq_mult4 #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // done must only appear while busy, never for two cycles in a row.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) done_total++;
      if (bus.done && !bus.busy) done_viol++;
      if (bus.done && done_prev) done_viol++;
      done_prev <= bus.done;
    end else begin
      done_prev <= 1'b0;
    end
  end

  // Called at a negedge; start is pulsed for one edge and the op runs to IDLE.
  // Returns at the negedge after DONE->IDLE, so the caller may start again at once.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic [7:0] exp,
                        input string tag);
    int busy_cyc;
    int done_cyc;
    int guard;
    busy_cyc = 0;
    done_cyc = 0;
    guard    = 0;
    bus.a     = ta;
    bus.b     = tb_v;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (bus.busy && guard < 20) begin
      busy_cyc++;
      if (bus.done) begin
        done_cyc++;
        check({tag, "_product"}, 32'(bus.product), 32'(exp));
      end
      @(negedge clk);
      guard++;
    end
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'd5);
    check({tag, "_done_count"}, 32'(done_cyc), 32'd1);
  endtask

  initial begin
    int guard;
    int done_snap;
    tests_run    = 0;
    tests_failed = 0;
    done_total   = 0;
    done_viol    = 0;
    done_prev    = 1'b0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;

    repeat (3) @(negedge clk);
    check("reset_product", 32'(bus.product), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_done", 32'(bus.done), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Largest operands.
    run_op(4'd15, 4'd15, 8'hE1, "max");
    @(negedge clk);
    check("idle_hold_product", 32'(bus.product), 32'hE1);
    check("idle_busy_low", 32'(bus.busy), 32'h0);

    // Zero operands on either side.
    run_op(4'd0, 4'd9, 8'h00, "zero_a");
    run_op(4'd9, 4'd0, 8'h00, "zero_b");

    // start held high; operands change mid-CALC and must not matter.
    bus.a     = 4'd3;
    bus.b     = 4'd5;
    bus.start = 1'b1;
    @(negedge clk);
    check("held_busy_after_accept", 32'(bus.busy), 32'h1);
    @(negedge clk);
    bus.a = 4'd7;
    bus.b = 4'd7;
    guard = 0;
    while (!bus.done && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("held_done_seen", 32'(bus.done), 32'h1);
    check("held_first_product", 32'(bus.product), 32'h0F);
    @(negedge clk);
    check("held_not_accepted_on_done", 32'(bus.busy), 32'h0);
    @(negedge clk);
    check("held_accepted_next", 32'(bus.busy), 32'h1);
    check("held_product_kept_in_calc", 32'(bus.product), 32'h0F);
    bus.start = 1'b0;
    guard = 0;
    while (!bus.done && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("held_second_done_seen", 32'(bus.done), 32'h1);
    check("held_second_product", 32'(bus.product), 32'h31);
    @(negedge clk);

    // Reset during CALC aborts the op without a done pulse.
    bus.a     = 4'd12;
    bus.b     = 4'd11;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    done_snap = done_total;
    rst_n = 1'b0;
    #1;
    check("abort_product", 32'(bus.product), 32'h0);
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_done", 32'(done_total), 32'(done_snap));
    run_op(4'd2, 4'd3, 8'h06, "after_reset");

    // All operand pairs at minimum start-to-start spacing.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(4'(i), 4'(j), 8'(i * j), $sformatf("sweep_%0d_%0d", i, j));
      end
    end

    check("done_outside_done_state", 32'(done_viol), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_mult4.md
SEQ_MULT4 -- requirements
Module: seq_mult4

Interface
REQ-001 Parameter: N, default 4, operand width in bits (legal range 2..8).
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  request to begin a multiply; sampled on the rising edge.
REQ-005 Port: a  input  N  multiplicand; sampled only on the accepting edge.
REQ-006 Port: b  input  N  multiplier; sampled only on the accepting edge.
REQ-007 Port: product  output  2N  unsigned a*b; registered.
REQ-008 Port: busy  output  1  high while a multiply is in progress (CALC or DONE state).
REQ-009 Port: done  output  1  single-cycle pulse; product is valid on that cycle.

Function
REQ-010 Operation SHALL be an unsigned shift-and-add multiply using one N-bit adder, iterated N times.
REQ-011 The adder SHALL be a ripple chain of N FA full-adder cells (sum = a^b^cin, majority carry), with cin of bit 0 tied to 0.
REQ-012 Internal state SHALL be: M (N-bit multiplicand), an accumulator ACC = {C (1 bit), HI (N bits), LO (N bits)}, and a cycle counter CNT of ceil(log2(N+1)) bits.
REQ-013 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-014 IDLE, start=1: M<=a, HI<=0, LO<=b, C<=0, CNT<=0, next state CALC (the accepting edge).
REQ-015 IDLE, start=0: no state change.
REQ-016 CALC, each edge, add step: if LO[0]=1, {C,HI} = HI+M (carry from the FA chain); else {C,HI} = {0,HI}.
REQ-017 CALC, each edge, shift step: ACC is shifted right by 1, i.e. {0,C,HI,LO[N-1:1]} truncated to 2N+1 bits; CNT<=CNT+1.
REQ-018 CALC SHALL transition to DONE on the edge where CNT = N-1, so CALC occupies exactly N edges.
REQ-019 On that same edge, product <= {HI,LO} after the shift.
REQ-020 DONE SHALL last exactly one cycle with done=1, then transition unconditionally to IDLE.
REQ-021 Latency: if start is accepted at edge k, done=1 and product are valid during the cycle after edge k+N.
REQ-022 Minimum start-to-start spacing is N+2 edges.
REQ-023 busy SHALL be 1 in CALC and DONE and 0 in IDLE; it is a registered state decode with no combinational path from start.
REQ-024 start SHALL be ignored in CALC and DONE, with no effect on M, ACC, CNT or product.
REQ-025 A start that is high in DONE SHALL NOT be accepted on the DONE->IDLE edge; it is accepted on the following edge if still high.
REQ-026 product SHALL hold its last value through IDLE and the next CALC phase, until the next DONE.
REQ-027 Changes on a or b after the accepting edge SHALL NOT affect the result.
REQ-028 The final HI+M addition SHALL NOT overflow 2N bits: the maximum result (2^N-1)^2 fits in 2N bits.

Reset
REQ-029 rst_n=0 SHALL immediately force the state to IDLE; product, busy, done, M, ACC and CNT SHALL all be forced to 0.
REQ-030 Reset asserted during CALC or DONE SHALL abort the operation; no done pulse is produced for the aborted operation.
REQ-031 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-032 N=4, a=15, b=15, start pulsed one cycle -> busy high for 5 cycles; done pulses once, 5 cycles after the accepting edge; product=0xE1 (225).
REQ-033 a=0, b=9, then a=9, b=0 -> product=0x00 each time; done pulses exactly once per start.
REQ-034 start held high continuously, a=3, b=5, with a/b changed to 7/7 mid-CALC -> product=0x0F; the next operation is accepted on the edge after DONE and yields 0x31.
REQ-035 Accept a=12, b=11, assert rst_n=0 on the second CALC cycle, release, then start a=2, b=3 -> outputs 0 during reset; no done for the aborted op; product=0x06.
REQ-036 Exhaustive sweep of all 256 (a,b) pairs, back-to-back at minimum spacing -> product equals a*b on every done pulse; done never asserted outside DONE.
